// File: rtl/avalon_bus_pkg.sv
// Shared types and constants for the Avalon memory arbiter.
package avalon_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GNT_IF,
        GNT_D
    } arb_state_t;

    typedef enum logic {
        PORT_IF,
        PORT_D
    } port_id_t;

    localparam logic [31:0] BUS_ERR_DATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/avalon_mem_arbiter.sv
// Purpose: shares one Avalon master between fetch and load/store requesters, round-robin on contention.
// Latency: strobe one cycle after a request is seen in IDLE; chained grants complete one per cycle.
// Backpressure: slave waitrequest passes to the granted port; ungranted requesters stall; watchdog aborts stuck grants.
module avalon_mem_arbiter
    import avalon_bus_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_read,
    input  logic [ADDR_W-1:0]     if_address,
    output logic [DATA_W-1:0]     if_readdata,
    output logic                  if_waitrequest,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_W-1:0]     d_address,
    input  logic [DATA_W-1:0]     d_writedata,
    input  logic [DATA_W/8-1:0]   d_byteenable,
    output logic [DATA_W-1:0]     d_readdata,
    output logic                  d_waitrequest,
    output logic [ADDR_W-1:0]     address,
    output logic                  read,
    output logic                  write,
    output logic [DATA_W-1:0]     writedata,
    output logic [DATA_W/8-1:0]   byteenable,
    input  logic                  waitrequest,
    input  logic [DATA_W-1:0]     readdata,
    output logic                  bus_err,
    output logic                  protocol_err
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit WD_EN = (TIMEOUT > 0);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic              read;
        logic              write;
        logic [DATA_W-1:0] writedata;
        logic [BE_W-1:0]   byteenable;
    } mst_req_t;

    arb_state_t        state, state_nxt;
    port_id_t          last_gnt, last_gnt_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    mst_req_t          mst;
    logic              if_req, d_req, gnt_d, gnt_req, done, wd_fire;
    logic [DATA_W-1:0] rdata;

    assign if_req = if_read;
    assign d_req  = d_read | d_write;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            last_gnt     <= PORT_IF;
            cnt          <= '0;
            bus_err      <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            state        <= state_nxt;
            last_gnt     <= last_gnt_nxt;
            cnt          <= cnt_nxt;
            bus_err      <= bus_err | wd_fire;
            protocol_err <= protocol_err | (d_read & d_write);
        end
    end

    always_comb begin
        state_nxt      = state;
        last_gnt_nxt   = last_gnt;
        cnt_nxt        = cnt;
        mst            = '0;
        gnt_d          = (state == GNT_D);
        gnt_req        = 1'b0;
        done           = 1'b0;
        wd_fire        = 1'b0;
        rdata          = readdata;
        if_waitrequest = if_req;
        d_waitrequest  = d_req;
        if_readdata    = '0;
        d_readdata     = '0;

        if (state == IDLE) begin
            cnt_nxt = '0;
            if (if_req && d_req)
                state_nxt = (last_gnt == PORT_IF) ? GNT_D : GNT_IF;
            else if (if_req)
                state_nxt = GNT_IF;
            else if (d_req)
                state_nxt = GNT_D;
        end else begin
            gnt_req = gnt_d ? d_req : if_req;
            done    = gnt_req && !waitrequest;
            // A slave that releases on the deadline cycle still completes normally.
            wd_fire = WD_EN && gnt_req && waitrequest && (cnt == CNT_MAX);
            if (wd_fire)
                rdata = DATA_W'(BUS_ERR_DATA);

            if (gnt_d) begin
                // Simultaneous read and write is resolved as a write.
                mst.address    = d_address;
                mst.read       = d_read & ~d_write;
                mst.write      = d_write;
                mst.writedata  = d_writedata;
                mst.byteenable = d_byteenable;
                d_waitrequest  = d_req && waitrequest && !wd_fire;
                d_readdata     = d_req ? rdata : '0;
            end else begin
                mst.address    = if_address;
                mst.read       = if_read;
                mst.byteenable = {BE_W{if_read}};
                if_waitrequest = if_req && waitrequest && !wd_fire;
                if_readdata    = if_req ? rdata : '0;
            end

            if (!gnt_req || wd_fire) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end else if (done) begin
                state_nxt = gnt_d ? (if_req ? GNT_IF : IDLE) : (d_req ? GNT_D : IDLE);
                cnt_nxt   = '0;
            end else if (cnt != CNT_MAX) begin
                cnt_nxt = cnt + 1'b1;
            end

            if (done || wd_fire)
                last_gnt_nxt = gnt_d ? PORT_D : PORT_IF;
        end

        if (reset) begin
            mst            = '0;
            if_waitrequest = 1'b1;
            d_waitrequest  = 1'b1;
            if_readdata    = '0;
            d_readdata     = '0;
        end
    end

    assign address    = mst.address;
    assign read       = mst.read;
    assign write      = mst.write;
    assign writedata  = mst.writedata;
    assign byteenable = mst.byteenable;

endmodule

// File: tb/tb_avalon_mem_arbiter.sv
// Self-checking bench for avalon_mem_arbiter: directed vectors, corner sequences, randomized traffic.
module tb_avalon_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_read;
    logic [31:0] if_address;
    logic [31:0] if_readdata;
    logic        if_waitrequest;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_address;
    logic [31:0] d_writedata;
    logic [3:0]  d_byteenable;
    logic [31:0] d_readdata;
    logic        d_waitrequest;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        bus_err;
    logic        protocol_err;

    logic        use_ram;
    logic [31:0] rdat;
    logic [31:0] ram     [16];
    logic [31:0] ref_mem [16];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    avalon_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .if_read(if_read), .if_address(if_address), .if_readdata(if_readdata),
        .if_waitrequest(if_waitrequest),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
        .d_byteenable(d_byteenable), .d_readdata(d_readdata), .d_waitrequest(d_waitrequest),
        .address(address), .read(read), .write(write), .writedata(writedata),
        .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata),
        .bus_err(bus_err), .protocol_err(protocol_err)
    );

    function automatic logic [31:0] init_val(input int i);
        return 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w, input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[b*8 +: 8] = w[b*8 +: 8];
        return r;
    endfunction

    // Slave memory: zero-latency read data, writes land on the accepting edge.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) ram[i] <= init_val(i);
        end else if (write && !waitrequest) begin
            ram[address[5:2]] <= merge(ram[address[5:2]], writedata, byteenable);
        end
    end

    assign readdata = use_ram ? ram[address[5:2]] : rdat;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_inputs;
        if_read = 1'b0; if_address = '0;
        d_read = 1'b0; d_write = 1'b0; d_address = '0; d_writedata = '0; d_byteenable = '0;
        waitrequest = 1'b0; rdat = '0;
    endtask

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b1;
        clear_inputs();
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct packed {
        logic        ir;   logic [31:0] ia;
        logic        dr;   logic dw; logic [31:0] da; logic [31:0] dwd; logic [3:0] dbe;
        logic [31:0] rd;
        logic        erd;  logic ewr; logic [31:0] ea; logic [31:0] ewd; logic [3:0] ebe;
        logic        eifw; logic edw; logic [31:0] eifrd; logic [31:0] edrd;
    } vec_t;

    function automatic vec_t mkv(
        input logic ir, input logic [31:0] ia,
        input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dwd, input logic [3:0] dbe,
        input logic [31:0] rd,
        input logic erd, input logic ewr, input logic [31:0] ea, input logic [31:0] ewd, input logic [3:0] ebe,
        input logic eifw, input logic edw, input logic [31:0] eifrd, input logic [31:0] edrd);
        vec_t v;
        v = {ir, ia, dr, dw, da, dwd, dbe, rd, erd, ewr, ea, ewd, ebe, eifw, edw, eifrd, edrd};
        return v;
    endfunction

    vec_t vecs [7];

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int n, if_age, d_age, if_max, d_max, exp_next, stall_run, n_done;
        logic if_cmp, d_cmp;

        use_ram = 1'b0;
        clear_inputs();
        reset = 1'b1;
        if_read = 1'b1; if_address = 32'h44; d_read = 1'b1; d_address = 32'h48;

        // Reset state, with both requesters already asking.
        repeat (3) @(negedge clk);
        chk1 ("rst_if_wait", if_waitrequest, 1'b1);
        chk1 ("rst_d_wait", d_waitrequest, 1'b1);
        chk1 ("rst_read", read, 1'b0);
        chk1 ("rst_write", write, 1'b0);
        chk32("rst_address", address, 32'h0);
        chk32("rst_writedata", writedata, 32'h0);
        chk32("rst_byteenable", {28'h0, byteenable}, 32'h0);
        chk32("rst_if_rdata", if_readdata, 32'h0);
        chk32("rst_d_rdata", d_readdata, 32'h0);
        chk1 ("rst_bus_err", bus_err, 1'b0);
        chk1 ("rst_protocol_err", protocol_err, 1'b0);
        clear_inputs();
        reset = 1'b0;

        // Contention from reset (data first, fetch chained), then fetch-only.
        vecs[0] = mkv(1'b1, 32'h8, 1'b0, 1'b1, 32'h100, 32'h70, 4'hF, 32'h1111_1111,
                      1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h0, 32'h0);
        vecs[1] = mkv(1'b1, 32'h8, 1'b0, 1'b1, 32'h100, 32'h70, 4'hF, 32'h1111_1111,
                      1'b0, 1'b1, 32'h100, 32'h70, 4'hF, 1'b1, 1'b0, 32'h0, 32'h1111_1111);
        vecs[2] = mkv(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h1111_1111,
                      1'b1, 1'b0, 32'h8, 32'h0, 4'hF, 1'b0, 1'b0, 32'h1111_1111, 32'h0);
        vecs[3] = mkv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h1111_1111,
                      1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        vecs[4] = mkv(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h2402_0010,
                      1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 32'h0);
        vecs[5] = mkv(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h2402_0010,
                      1'b1, 1'b0, 32'h4, 32'h0, 4'hF, 1'b0, 1'b0, 32'h2402_0010, 32'h0);
        vecs[6] = mkv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h2402_0010,
                      1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            if_read = vecs[i].ir; if_address = vecs[i].ia;
            d_read = vecs[i].dr; d_write = vecs[i].dw; d_address = vecs[i].da;
            d_writedata = vecs[i].dwd; d_byteenable = vecs[i].dbe;
            waitrequest = 1'b0; rdat = vecs[i].rd;
            @(negedge clk);
            chk1 ($sformatf("vec%0d_read", i), read, vecs[i].erd);
            chk1 ($sformatf("vec%0d_write", i), write, vecs[i].ewr);
            chk32($sformatf("vec%0d_address", i), address, vecs[i].ea);
            chk32($sformatf("vec%0d_writedata", i), writedata, vecs[i].ewd);
            chk32($sformatf("vec%0d_byteenable", i), {28'h0, byteenable}, {28'h0, vecs[i].ebe});
            chk1 ($sformatf("vec%0d_if_wait", i), if_waitrequest, vecs[i].eifw);
            chk1 ($sformatf("vec%0d_d_wait", i), d_waitrequest, vecs[i].edw);
            chk32($sformatf("vec%0d_if_rdata", i), if_readdata, vecs[i].eifrd);
            chk32($sformatf("vec%0d_d_rdata", i), d_readdata, vecs[i].edrd);
        end

        // Both held requesting: grants alternate D, IF, ... one per cycle after arbitration.
        do_reset();
        n = 0;
        for (int c = 0; c < 14 && n < 6; c++) begin
            @(posedge clk); #1;
            if_read = 1'b1; if_address = 32'h80; d_read = 1'b1; d_address = 32'h40; rdat = 32'h1234;
            @(negedge clk);
            if (!d_waitrequest || !if_waitrequest) begin
                chk1 ($sformatf("alt%0d_is_d", n), !d_waitrequest, (n % 2) == 0);
                chk32($sformatf("alt%0d_cycle", n), 32'(c), 32'(n + 1));
                n++;
            end
        end
        chk32("alt_count", 32'(n), 32'd6);
        @(posedge clk); #1;
        clear_inputs();

        // Slave stalls 3 cycles on a data read.
        do_reset();
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            d_read = 1'b1; d_address = 32'hC; rdat = 32'hCAFE_F00D; waitrequest = (c < 4);
            @(negedge clk);
            if (c == 0) begin
                chk1("stall_arb_read", read, 1'b0);
                chk1("stall_arb_d_wait", d_waitrequest, 1'b1);
            end else begin
                chk1 ($sformatf("stall%0d_read", c), read, 1'b1);
                chk32($sformatf("stall%0d_address", c), address, 32'hC);
                chk1 ($sformatf("stall%0d_d_wait", c), d_waitrequest, c < 4);
                if (c == 4) chk32("stall_d_rdata", d_readdata, 32'hCAFE_F00D);
            end
        end
        @(posedge clk); #1;
        clear_inputs();

        // Slave never releases: watchdog forces completion after 4 stall cycles.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            d_read = (c <= 5); d_address = 32'h10; waitrequest = 1'b1; rdat = 32'h5;
            @(negedge clk);
            if (c >= 1 && c <= 4) begin
                chk1($sformatf("wd%0d_d_wait", c), d_waitrequest, 1'b1);
                chk1($sformatf("wd%0d_read", c), read, 1'b1);
            end else if (c == 5) begin
                chk1 ("wd_force_d_wait", d_waitrequest, 1'b0);
                chk32("wd_force_rdata", d_readdata, 32'hFFFF_FFFF);
                chk1 ("wd_bus_err_not_yet", bus_err, 1'b0);
            end else if (c >= 6) begin
                chk1($sformatf("wd%0d_bus_err_sticky", c), bus_err, 1'b1);
                chk1($sformatf("wd%0d_idle_read", c), read, 1'b0);
            end
        end

        // Reset pulsed during a stalled fetch, then re-arbitration from IDLE.
        do_reset();
        chk1("rst2_bus_err_clear", bus_err, 1'b0);
        @(posedge clk); #1;
        if_read = 1'b1; if_address = 32'h20; waitrequest = 1'b1;
        @(negedge clk);
        chk1("rst2_arb_read", read, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk1("rst2_stalled_read", read, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk1 ("rst2_read_dropped", read, 1'b0);
        chk1 ("rst2_if_wait", if_waitrequest, 1'b1);
        chk32("rst2_address", address, 32'h0);
        @(posedge clk); #1;
        waitrequest = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk1("rst2_rearb_read", read, 1'b0);
        chk1("rst2_rearb_if_wait", if_waitrequest, 1'b1);
        @(negedge clk);
        chk1 ("rst2_regrant_read", read, 1'b1);
        chk32("rst2_regrant_address", address, 32'h20);
        chk1 ("rst2_regrant_if_wait", if_waitrequest, 1'b0);

        // Read and write asserted together: issued as a write, error latched.
        @(posedge clk); #1;
        if_read = 1'b0;
        d_read = 1'b1; d_write = 1'b1; d_address = 32'h30; d_writedata = 32'h55; d_byteenable = 4'hF;
        @(negedge clk);
        chk1("perr_arb_write", write, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk1 ("perr_write", write, 1'b1);
        chk1 ("perr_read", read, 1'b0);
        chk32("perr_address", address, 32'h30);
        chk1 ("perr_flag", protocol_err, 1'b1);
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        chk1("perr_sticky", protocol_err, 1'b1);

        // Randomized traffic against a memory-level scoreboard.
        do_reset();
        use_ram = 1'b1;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
        if_age = 0; d_age = 0; if_max = 0; d_max = 0; exp_next = -1; stall_run = 0; n_done = 0;
        if_cmp = 1'b0; d_cmp = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk); #1;
            if (!if_read || if_cmp) begin
                if_read = ($urandom_range(0, 1) == 1);
                if_address = 32'($urandom_range(0, 15)) << 2;
                if_age = 0;
            end
            if (!(d_read || d_write) || d_cmp) begin
                case ($urandom_range(0, 2))
                    0: begin d_read = 1'b0; d_write = 1'b0; end
                    1: begin d_read = 1'b1; d_write = 1'b0; end
                    default: begin d_read = 1'b0; d_write = 1'b1; end
                endcase
                d_address = 32'($urandom_range(0, 15)) << 2;
                d_writedata = $urandom;
                d_byteenable = 4'($urandom_range(0, 15));
                d_age = 0;
            end
            waitrequest = (stall_run < 2) && ($urandom_range(0, 2) == 0);
            @(negedge clk);
            if_cmp = if_read && !if_waitrequest;
            d_cmp = (d_read || d_write) && !d_waitrequest;
            if (read || write) stall_run = waitrequest ? stall_run + 1 : 0;
            if (if_cmp || d_cmp) begin
                n_done++;
                chk1("rnd_single_completion", if_cmp && d_cmp, 1'b0);
                if (exp_next >= 0) chk1("rnd_round_robin", d_cmp, exp_next == 1);
                exp_next = -1;
                if (if_cmp && (d_read || d_write)) exp_next = 1;
                else if (d_cmp && if_read) exp_next = 0;
            end
            if (if_cmp) chk32("rnd_if_rdata", if_readdata, ref_mem[if_address[5:2]]);
            if (d_cmp && d_write)
                ref_mem[d_address[5:2]] = merge(ref_mem[d_address[5:2]], d_writedata, d_byteenable);
            else if (d_cmp)
                chk32("rnd_d_rdata", d_readdata, ref_mem[d_address[5:2]]);
            if (if_read && !if_cmp) begin if_age++; if (if_age > if_max) if_max = if_age; end
            if ((d_read || d_write) && !d_cmp) begin d_age++; if (d_age > d_max) d_max = d_age; end
        end
        chk1("rnd_if_wait_bounded", if_max <= 12, 1'b1);
        chk1("rnd_d_wait_bounded", d_max <= 12, 1'b1);
        chk1("rnd_progress", n_done > 100, 1'b1);
        chk1("rnd_no_bus_err", bus_err, 1'b0);
        chk1("rnd_no_protocol_err", protocol_err, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
